// File: rtl/tmr_voted_accum.sv
// Triple-redundant XOR accumulator. Three copies are majority-voted to form out.
// Disagreement between copies is flagged one cycle late and counted with saturation.
module tmr_voted_accum #(
    parameter int WIDTH         = 8,
    parameter int ERR_CNT_W     = 8,
    parameter int VOTE_FEEDBACK = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [WIDTH-1:0]     in,
    input  logic                 clr,
    input  logic                 inj_en,
    input  logic [1:0]           inj_sel,
    input  logic [WIDTH-1:0]     inj_mask,
    input  logic                 err_cnt_clr,
    output logic [WIDTH-1:0]     out,
    output logic                 err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    logic [2:0][WIDTH-1:0] w_st;
    logic [WIDTH-1:0]      w_st_a;
    logic [WIDTH-1:0]      w_st_b;
    logic [WIDTH-1:0]      w_st_c;
    logic                  w_mismatch;
    logic                  r_err;
    logic [ERR_CNT_W-1:0]  r_err_cnt;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_copy
            logic [WIDTH-1:0] r_st;
            logic [WIDTH-1:0] w_base;
            logic [WIDTH-1:0] w_next;
            logic [WIDTH-1:0] w_flip;

            // With feedback every copy rebuilds from the vote, so an upset lasts one edge.
            assign w_base = (VOTE_FEEDBACK != 0) ? out : r_st;

            always_comb begin
                w_next = w_base;
                if (clr) begin
                    w_next = '0;
                end else if (en) begin
                    w_next = w_base ^ in;
                end
            end

            assign w_flip = (inj_en && (inj_sel == 2'(gi))) ? inj_mask : '0;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_st <= '0;
                end else begin
                    r_st <= w_next ^ w_flip;
                end
            end

            assign w_st[gi] = r_st;
        end
    endgenerate

    assign w_st_a     = w_st[0];
    assign w_st_b     = w_st[1];
    assign w_st_c     = w_st[2];
    assign out        = (w_st_a & w_st_b) | (w_st_b & w_st_c) | (w_st_a & w_st_c);
    assign w_mismatch = |((w_st_a ^ w_st_b) | (w_st_b ^ w_st_c));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err     <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            r_err <= w_mismatch;
            if (err_cnt_clr) begin
                r_err_cnt <= '0;
            end else if (w_mismatch && !(&r_err_cnt)) begin
                r_err_cnt <= r_err_cnt + 1'b1;
            end
        end
    end

    assign err     = r_err;
    assign err_cnt = r_err_cnt;

endmodule

// File: tb/tb_tmr_voted_accum.sv
// Drives three accumulator variants (voted feedback, free-running copies, 2-bit counter)
// with one shared stimulus and compares against hand-computed expectations.
module tb_tmr_voted_accum;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [7:0] din;
    logic       clr;
    logic       inj_en;
    logic [1:0] inj_sel;
    logic [7:0] inj_mask;
    logic       ecc;

    logic [7:0] out1, out0, out2;
    logic       err1, err0, err2;
    logic [7:0] cnt1, cnt0;
    logic [1:0] cnt2;

    int errors = 0;
    int checks = 0;

    tmr_voted_accum #(.WIDTH(8), .ERR_CNT_W(8), .VOTE_FEEDBACK(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .in(din), .clr(clr), .inj_en(inj_en),
        .inj_sel(inj_sel), .inj_mask(inj_mask), .err_cnt_clr(ecc),
        .out(out1), .err(err1), .err_cnt(cnt1)
    );

    tmr_voted_accum #(.WIDTH(8), .ERR_CNT_W(8), .VOTE_FEEDBACK(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .en(en), .in(din), .clr(clr), .inj_en(inj_en),
        .inj_sel(inj_sel), .inj_mask(inj_mask), .err_cnt_clr(ecc),
        .out(out0), .err(err0), .err_cnt(cnt0)
    );

    tmr_voted_accum #(.WIDTH(8), .ERR_CNT_W(2), .VOTE_FEEDBACK(0)) dut2 (
        .clk(clk), .rst_n(rst_n), .en(en), .in(din), .clr(clr), .inj_en(inj_en),
        .inj_sel(inj_sel), .inj_mask(inj_mask), .err_cnt_clr(ecc),
        .out(out2), .err(err2), .err_cnt(cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       en;
        logic [7:0] din;
        logic       clr;
        logic       ie;
        logic [1:0] sel;
        logic [7:0] mask;
        logic       ecc;
        logic [7:0] out;
        logic       e1;
        logic [7:0] c1;
        logic       e0;
        logic [7:0] c0;
        logic [1:0] c2;
        logic       chk;
        logic [7:0] a1;
        logic [7:0] b1;
    } vec_t;

    vec_t vec [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic e, input logic [7:0] d, input logic c, input logic ie,
                         input logic [1:0] s, input logic [7:0] m, input logic ec);
        en = e; din = d; clr = c; inj_en = ie; inj_sel = s; inj_mask = m; ecc = ec;
    endtask

    initial begin
        //          en  din    clr ie sel mask   ecc out    e1 c1     e0 c0     c2  chk a1     b1
        vec[0]  = '{1'b1, 8'h0F, 1'b0, 1'b0, 2'd3, 8'h00, 1'b0, 8'h0F, 1'b0, 8'd0, 1'b0, 8'd0, 2'd0, 1'b0, 8'h00, 8'h00};
        vec[1]  = '{1'b1, 8'hF0, 1'b0, 1'b0, 2'd3, 8'h00, 1'b0, 8'hFF, 1'b0, 8'd0, 1'b0, 8'd0, 2'd0, 1'b0, 8'h00, 8'h00};
        vec[2]  = '{1'b1, 8'h33, 1'b0, 1'b0, 2'd3, 8'h00, 1'b0, 8'hCC, 1'b0, 8'd0, 1'b0, 8'd0, 2'd0, 1'b0, 8'h00, 8'h00};
        vec[3]  = '{1'b0, 8'h00, 1'b0, 1'b1, 2'd1, 8'h01, 1'b0, 8'hCC, 1'b0, 8'd0, 1'b0, 8'd0, 2'd0, 1'b1, 8'hCC, 8'hCD};
        vec[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 2'd3, 8'h00, 1'b0, 8'hCC, 1'b1, 8'd1, 1'b1, 8'd1, 2'd1, 1'b1, 8'hCC, 8'hCC};
        vec[5]  = '{1'b0, 8'h00, 1'b0, 1'b0, 2'd3, 8'h00, 1'b0, 8'hCC, 1'b0, 8'd1, 1'b1, 8'd2, 2'd2, 1'b0, 8'h00, 8'h00};
        vec[6]  = '{1'b0, 8'h00, 1'b0, 1'b0, 2'd3, 8'h00, 1'b0, 8'hCC, 1'b0, 8'd1, 1'b1, 8'd3, 2'd3, 1'b0, 8'h00, 8'h00};
        vec[7]  = '{1'b0, 8'h00, 1'b0, 1'b0, 2'd3, 8'h00, 1'b0, 8'hCC, 1'b0, 8'd1, 1'b1, 8'd4, 2'd3, 1'b0, 8'h00, 8'h00};
        vec[8]  = '{1'b0, 8'h00, 1'b0, 1'b0, 2'd3, 8'h00, 1'b0, 8'hCC, 1'b0, 8'd1, 1'b1, 8'd5, 2'd3, 1'b0, 8'h00, 8'h00};
        vec[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 2'd3, 8'h00, 1'b1, 8'hCC, 1'b0, 8'd0, 1'b1, 8'd0, 2'd0, 1'b0, 8'h00, 8'h00};
        vec[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 2'd3, 8'h00, 1'b0, 8'h00, 1'b0, 8'd0, 1'b1, 8'd1, 2'd1, 1'b0, 8'h00, 8'h00};
        vec[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 2'd3, 8'h00, 1'b0, 8'h00, 1'b0, 8'd0, 1'b0, 8'd1, 2'd1, 1'b0, 8'h00, 8'h00};
        vec[12] = '{1'b1, 8'hAA, 1'b0, 1'b0, 2'd3, 8'h00, 1'b0, 8'hAA, 1'b0, 8'd0, 1'b0, 8'd1, 2'd1, 1'b0, 8'h00, 8'h00};
        vec[13] = '{1'b1, 8'hAA, 1'b1, 1'b0, 2'd3, 8'h00, 1'b0, 8'h00, 1'b0, 8'd0, 1'b0, 8'd1, 2'd1, 1'b0, 8'h00, 8'h00};
        vec[14] = '{1'b0, 8'h00, 1'b1, 1'b1, 2'd0, 8'h80, 1'b0, 8'h00, 1'b0, 8'd0, 1'b0, 8'd1, 2'd1, 1'b1, 8'h80, 8'h00};
        vec[15] = '{1'b0, 8'h00, 1'b0, 1'b0, 2'd3, 8'h00, 1'b0, 8'h00, 1'b1, 8'd1, 1'b1, 8'd2, 2'd2, 1'b1, 8'h00, 8'h00};

        rst_n = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 1'b0, 2'd3, 8'h00, 1'b0);
        #12;
        chk("reset_out", 32'(out1), 32'h00);
        chk("reset_err", 32'(err1), 32'h0);
        chk("reset_cnt", 32'(cnt1), 32'h0);
        chk("reset_cnt_w2", 32'(cnt2), 32'h0);
        #5 rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            drive(vec[i].en, vec[i].din, vec[i].clr, vec[i].ie, vec[i].sel, vec[i].mask, vec[i].ecc);
            step();
            $display("vec %0d: out=%02h/%02h/%02h err=%0d/%0d cnt=%0d/%0d/%0d",
                     i, out1, out0, out2, err1, err0, cnt1, cnt0, cnt2);
            chk($sformatf("v%0d_out_fb", i), 32'(out1), 32'(vec[i].out));
            chk($sformatf("v%0d_out_nofb", i), 32'(out0), 32'(vec[i].out));
            chk($sformatf("v%0d_out_w2", i), 32'(out2), 32'(vec[i].out));
            chk($sformatf("v%0d_err_fb", i), 32'(err1), 32'(vec[i].e1));
            chk($sformatf("v%0d_cnt_fb", i), 32'(cnt1), 32'(vec[i].c1));
            chk($sformatf("v%0d_err_nofb", i), 32'(err0), 32'(vec[i].e0));
            chk($sformatf("v%0d_cnt_nofb", i), 32'(cnt0), 32'(vec[i].c0));
            chk($sformatf("v%0d_cnt_w2", i), 32'(cnt2), 32'(vec[i].c2));
            if (vec[i].chk) begin
                chk($sformatf("v%0d_stA_fb", i), 32'(dut1.w_st_a), 32'(vec[i].a1));
                chk($sformatf("v%0d_stB_fb", i), 32'(dut1.w_st_b), 32'(vec[i].b1));
            end
        end

        // Build out=0x5A with err_cnt=7 on the voted-feedback instance.
        drive(1'b0, 8'h00, 1'b1, 1'b0, 2'd3, 8'h00, 1'b1);
        step();
        drive(1'b1, 8'h5A, 1'b0, 1'b0, 2'd3, 8'h00, 1'b0);
        step();
        chk("seq_out_5a", 32'(out1), 32'h5A);
        for (int k = 0; k < 7; k++) begin
            drive(1'b0, 8'h00, 1'b0, 1'b1, 2'd1, 8'h01, 1'b0);
            step();
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0, 2'd3, 8'h00, 1'b0);
        step();
        $display("pre-reset: out=%02h err=%0d cnt=%0d", out1, err1, cnt1);
        chk("seq_cnt_7", 32'(cnt1), 32'd7);
        chk("seq_out_held", 32'(out1), 32'h5A);
        chk("seq_err_hi", 32'(err1), 32'h1);

        // Asynchronous reset between edges with an injection pending.
        #3;
        drive(1'b1, 8'hFF, 1'b0, 1'b1, 2'd1, 8'hFF, 1'b0);
        rst_n = 1'b0;
        #1;
        $display("async reset: out=%02h err=%0d cnt=%0d", out1, err1, cnt1);
        chk("async_out", 32'(out1), 32'h00);
        chk("async_err", 32'(err1), 32'h0);
        chk("async_cnt", 32'(cnt1), 32'h0);
        chk("async_cnt_nofb", 32'(cnt0), 32'h0);
        step();
        chk("held_stB", 32'(dut1.w_st_b), 32'h00);
        chk("held_out", 32'(out1), 32'h00);
        #2;
        drive(1'b1, 8'h3C, 1'b0, 1'b0, 2'd3, 8'h00, 1'b0);
        rst_n = 1'b1;
        step();
        $display("post-reset: out=%02h err=%0d cnt=%0d", out1, err1, cnt1);
        chk("post_out", 32'(out1), 32'h3C);
        chk("post_stB", 32'(dut1.w_st_b), 32'h3C);
        chk("post_err", 32'(err1), 32'h0);
        chk("post_cnt", 32'(cnt1), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tmr_voted_accum.md
TMR_VOTED_ACCUM -- requirements
Module: tmr_voted_accum

Interface
REQ-001 The block SHALL provide parameter WIDTH, default 8, as the width of the accumulator state and data path.
REQ-002 The block SHALL provide parameter ERR_CNT_W, default 8, as the width of the error counter.
REQ-003 The block SHALL provide parameter VOTE_FEEDBACK, default 1: 1 means each copy updates from the voted state (self-correcting); 0 means each copy updates from its own state.
REQ-004 The block SHALL have one clock and an asynchronous active-low reset.
REQ-005 Port: clk  input  1  the single clock; all state changes on its rising edge.
REQ-006 Port: rst_n  input  1  asynchronous active-low reset.
REQ-007 Port: en  input  1  accumulate enable.
REQ-008 Port: in  input  WIDTH  data XORed into the state when en=1.
REQ-009 Port: clr  input  1  synchronous clear of all three state copies.
REQ-010 Port: inj_en  input  1  fault-injection strobe, used for verification.
REQ-011 Port: inj_sel  input  2  selects the copy to corrupt: 0=A, 1=B, 2=C, 3=none.
REQ-012 Port: inj_mask  input  WIDTH  bits to flip in the selected copy.
REQ-013 Port: err_cnt_clr  input  1  synchronous clear of err_cnt.
REQ-014 Port: out  output  WIDTH  bitwise majority of copies A/B/C.
REQ-015 Port: err  output  1  registered one-cycle mismatch flag.
REQ-016 Port: err_cnt  output  ERR_CNT_W  saturating count of cycles with a mismatch.

Function
REQ-017 The state SHALL be held in three WIDTH-bit registers, stA, stB and stC.
REQ-018 The voted state SHALL be: out = (stA&stB)|(stB&stC)|(stA&stC), purely combinational from the registers.
REQ-019 Per copy X, the base value SHALL be the voted state if VOTE_FEEDBACK=1, and stX if VOTE_FEEDBACK=0.
REQ-020 Per copy X, the next value SHALL be chosen by priority:
  - clr=1: 0
  - else en=1: base ^ in
  - else: base
REQ-021 When inj_en=1 and inj_sel selects copy X, copy X SHALL take its next value from REQ-020 XOR inj_mask; the other copies are unaffected.
REQ-022 With inj_sel=3, fault injection SHALL have no effect.
REQ-023 Latency: a value applied on in with en=1 SHALL appear in out one clock after the sampling edge.
REQ-024 The mismatch signal SHALL be defined as: mismatch = |((stA^stB)|(stB^stC)).
REQ-025 err SHALL equal the value of mismatch at the previous rising edge, i.e. it is a registered flag.
REQ-026 err_cnt SHALL increment by 1 at each edge where mismatch=1 and SHALL saturate at all-ones without wrapping.
REQ-027 When err_cnt_clr=1 and an increment coincide, err_cnt SHALL become 0 (clear wins).
REQ-028 With VOTE_FEEDBACK=1, a single-copy upset SHALL be repaired at the next edge.
  - Consequence: mismatch is high for exactly one cycle.
  - out is never disturbed.
REQ-029 With VOTE_FEEDBACK=0, a single-copy upset SHALL persist until clr or reset, and out SHALL still be correct.
REQ-030 If clr and inj_en are both asserted, the selected copy SHALL load inj_mask (0 ^ inj_mask).

Reset
REQ-031 While rst_n=0, asynchronously, the following SHALL be forced:
  - stA, stB, stC = 0
  - out = 0
  - err = 0
  - err_cnt = 0
REQ-032 Reset SHALL take effect mid-operation, regardless of en, clr or inj_en, and SHALL discard any pending injection.
REQ-033 After rst_n rises, the first state update SHALL occur at the next rising edge of clk.

Verification
REQ-034 Accumulate test (WIDTH=8): en=1 with in=0x0F, then in=0xF0, then in=0x33 -> out = 0x0F, then 0xFF, then 0xCC; err=0 throughout.
REQ-035 Repair test (VOTE_FEEDBACK=1, state 0xCC): inj_en=1, inj_sel=1, inj_mask=0x01 for one cycle ->
  - out stays 0xCC
  - err=1 for exactly one cycle
  - err_cnt increases by 1
  - stB returns to 0xCC
REQ-036 Persistent-fault test (VOTE_FEEDBACK=0): same injection, idle 5 cycles ->
  - out stays 0xCC
  - err stays 1
  - err_cnt = 5 after five mismatch edges
  - clr=1 -> all copies 0, err deasserts one cycle later
REQ-037 Saturation test (ERR_CNT_W=2, VOTE_FEEDBACK=0, persistent fault): err_cnt SHALL read 1, 2, 3, 3, 3; then err_cnt_clr=1 on a mismatch edge -> err_cnt = 0.
REQ-038 Priority test: clr=1 and en=1 with in=0xAA -> out = 0x00; clr=1 with inj_en=1, inj_sel=0, inj_mask=0x80 -> stA = 0x80, out = 0x00.
REQ-039 Reset test: assert rst_n=0 asynchronously between edges while out=0x5A and err_cnt=7 -> out, err and err_cnt are 0 immediately, without a clock edge.
